// File: rtl/cdb_arb_pkg.sv
// Shared CDB arbitration constants. The ROB, reservation stations and the
// load/store buffer snoop logic use the same values, so that a tag of NO_TAG
// means "no broadcast" everywhere on the common data bus.
package cdb_arb_pkg;

   localparam int NUM_REQ = 4;    // result producers: ALU, MEMU, two spares
   localparam int ROBEN_W = 5;    // ROB entry tag width
   localparam int DATA_W  = 32;   // result width

   localparam logic [ROBEN_W-1:0] NO_TAG = '0;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2: two-winner round-robin picker.
//   held  : per-producer request vector
//   ptr   : index searched first; the search wraps modulo N
//   gnt1  : one-hot, first held producer at or after ptr (CDB port 1)
//   gnt2  : one-hot, next held producer after the port-1 winner (CDB port 2)
//   vld1/2: the matching grant vector is non-zero
module rr_pick2 #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     held,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt1,
   output logic [N-1:0]     gnt2,
   output logic             vld1,
   output logic             vld2
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt1 = '0;
      gnt2 = '0;
      vld1 = 1'b0;
      vld2 = 1'b0;
      idx  = '0;
      for (int k = 0; k < N; k++) begin
         idx = PTR_W'((int'(ptr) + k) % N);
         if (held[idx]) begin
            if (!vld1) begin
               gnt1[idx] = 1'b1;
               vld1      = 1'b1;
            end else if (!vld2) begin
               gnt2[idx] = 1'b1;
               vld2      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects results from NUM_REQ producers into one holding
// register each and broadcasts up to two per cycle on the common data bus.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   flush               : ROB flush, drops every held result
//   req_valid/roben/data: per-producer result offer (slice i = producer i)
//   req_ready           : producer i may transfer this cycle (combinational)
//   cdb_roben1/2, cdb_data1/2 : registered broadcasts, tag 0 = idle
//   pending             : holding-register occupancy
//   conflict_count      : saturating count of cycles with more than two held
module cdb_arbiter #(
   parameter int NUM_REQ = cdb_arb_pkg::NUM_REQ,
   parameter int ROBEN_W = cdb_arb_pkg::ROBEN_W,
   parameter int DATA_W  = cdb_arb_pkg::DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*ROBEN_W-1:0] req_roben,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [ROBEN_W-1:0]         cdb_roben1,
   output logic [ROBEN_W-1:0]         cdb_roben2,
   output logic [DATA_W-1:0]          cdb_data1,
   output logic [DATA_W-1:0]          cdb_data2,
   output logic [NUM_REQ-1:0]         pending,
   output logic [15:0]                conflict_count
);

   import cdb_arb_pkg::*;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]              held;
   logic [NUM_REQ-1:0][ROBEN_W-1:0] tag_q;
   logic [NUM_REQ-1:0][DATA_W-1:0]  data_q;
   logic [PTR_W-1:0]                rr_ptr;

   logic [NUM_REQ-1:0] gnt1, gnt2, grant, xfer;
   logic               vld1, vld2;
   logic [ROBEN_W-1:0] sel_tag1, sel_tag2;
   logic [DATA_W-1:0]  sel_data1, sel_data2;
   logic [PTR_W-1:0]   last_idx, ptr_nxt;
   int                 held_cnt;
   logic               dup_tag;

   rr_pick2 #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .held (held),
      .ptr  (rr_ptr),
      .gnt1 (gnt1),
      .gnt2 (gnt2),
      .vld1 (vld1),
      .vld2 (vld2)
   );

   // Ready depends only on held state and grants, never on req_valid.
   assign grant     = gnt1 | gnt2;
   assign req_ready = {NUM_REQ{~flush & ~rst}} & (~held | grant);
   assign xfer      = req_valid & req_ready;
   assign pending   = held;

   always_comb begin
      sel_tag1  = '0;
      sel_tag2  = '0;
      sel_data1 = '0;
      sel_data2 = '0;
      last_idx  = rr_ptr;
      held_cnt  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_tag1  = sel_tag1  | (tag_q[i]  & {ROBEN_W{gnt1[i]}});
         sel_tag2  = sel_tag2  | (tag_q[i]  & {ROBEN_W{gnt2[i]}});
         sel_data1 = sel_data1 | (data_q[i] & {DATA_W{gnt1[i]}});
         sel_data2 = sel_data2 | (data_q[i] & {DATA_W{gnt2[i]}});
         // The port-2 winner, when present, is the later one in search order.
         if (vld2 ? gnt2[i] : gnt1[i])
            last_idx = PTR_W'(i);
         if (held[i])
            held_cnt = held_cnt + 1;
      end
      ptr_nxt = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held           <= '0;
         tag_q          <= '0;
         data_q         <= '0;
         cdb_roben1     <= '0;
         cdb_roben2     <= '0;
         cdb_data1      <= '0;
         cdb_data2      <= '0;
         rr_ptr         <= '0;
         conflict_count <= '0;
      end else if (flush) begin
         held       <= '0;
         cdb_roben1 <= '0;
         cdb_roben2 <= '0;
         cdb_data1  <= '0;
         cdb_data2  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            // A tag-0 transfer is swallowed; a granted register may refill at once.
            if (xfer[i] && (req_roben[i*ROBEN_W +: ROBEN_W] != ROBEN_W'(NO_TAG))) begin
               held[i]   <= 1'b1;
               tag_q[i]  <= req_roben[i*ROBEN_W +: ROBEN_W];
               data_q[i] <= req_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               held[i] <= 1'b0;
            end
         end
         cdb_roben1 <= sel_tag1;
         cdb_roben2 <= sel_tag2;
         cdb_data1  <= sel_data1;
         cdb_data2  <= sel_data2;
         if (vld1)
            rr_ptr <= ptr_nxt;
         if ((held_cnt > 2) && (conflict_count != 16'hFFFF))
            conflict_count <= conflict_count + 16'd1;
      end
   end

   // Two producers transferring the same live tag in one cycle is an upstream bug.
   always_comb begin
      dup_tag = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         for (int j = i + 1; j < NUM_REQ; j++)
            if (xfer[i] && xfer[j] &&
                (req_roben[i*ROBEN_W +: ROBEN_W] != ROBEN_W'(NO_TAG)) &&
                (req_roben[i*ROBEN_W +: ROBEN_W] == req_roben[j*ROBEN_W +: ROBEN_W]))
               dup_tag = 1'b1;
   end

   a_no_dup_tag: assert property (@(posedge clk) disable iff (rst) !dup_tag);

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of result producers (ALU, MEMU, two spares).
REQ-002 Parameter ROBEN_W, default 5, ROB tag width; DATA_W, default 32, result width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  ROB flush; discards all pending results.
REQ-006 req_valid  input  NUM_REQ  per-producer result valid.
REQ-007 req_roben  input  NUM_REQ*ROBEN_W  per-producer ROB tag, slice i = producer i.
REQ-008 req_data  input  NUM_REQ*DATA_W  per-producer result value.
REQ-009 req_ready  output  NUM_REQ  producer i may present a result this cycle.
REQ-010 cdb_roben1, cdb_roben2  output  ROBEN_W each  broadcast tags; 0 = no broadcast.
REQ-011 cdb_data1, cdb_data2  output  DATA_W each  broadcast values.
REQ-012 pending  output  NUM_REQ  holding-register occupancy per producer.
REQ-013 conflict_count  output  16  saturating count of cycles with a held result not granted.

Function
REQ-014 One holding register per producer (tag, data, held bit); transfer occurs on an edge where req_valid[i] and req_ready[i] are both 1.
REQ-015 req_ready[i] = ~flush & (~held[i] | grant[i]); grant depends on held state only, so no combinational path from req_valid to req_ready.
REQ-016 A transfer with tag 0 is accepted and discarded; held[i] is not set.
REQ-017 Each cycle, rr_ptr selects up to two held producers: the first held at or after rr_ptr (modulo NUM_REQ) goes to port 1, the next goes to port 2.
REQ-018 On the edge, port-1/port-2 winners load cdb_roben/data 1/2; an unused port loads tag 0 and data 0.
REQ-019 Granted held bits clear on the same edge unless the same producer transfers a new result, which then occupies the register.
REQ-020 Latency: result accepted at edge k broadcasts at edge k+1 at the earliest; each output stays valid for exactly one cycle.
REQ-021 rr_ptr advances to (last granted index + 1) mod NUM_REQ; unchanged when nothing is granted.
REQ-022 conflict_count increments when more than two results are held at the start of the cycle; it saturates at 16'hFFFF.
REQ-023 flush=1: on the next edge, all held bits clear, both CDB outputs load tag 0/data 0, and no transfer occurs. rr_ptr and conflict_count are kept.
REQ-024 Fairness: a held result is granted within ceil(NUM_REQ/2) cycles when there is no flush.
REQ-025 Duplicate non-zero tags in one cycle are a producer error, covered by an assertion only; no correction in hardware.

Reset
REQ-026 rst clears held bits, tags and data to 0, sets cdb_roben1/2 and cdb_data1/2 to 0, rr_ptr to 0 and conflict_count to 0, with immediate (asynchronous) effect.
REQ-027 During rst, req_ready is 0. A result in flight when rst asserts is lost.
REQ-028 The first transfer is possible on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package cdb_arb_pkg holds ROBEN_W, DATA_W, NUM_REQ and NO_TAG=0, and is reused by the ROB, RS and load/store buffer CDB snoop logic.
REQ-030 A single sub-module rr_pick2 (two-winner round-robin picker: held vector + pointer in, two one-hot grants + valids out) is instantiated once.
REQ-031 All outputs except req_ready are registered.

Verification
REQ-032 Single result: producer 0 sends tag 3, data 0x0000_00AA at edge 1 -> cdb_roben1=3, cdb_data1=0xAA after edge 2; cdb_roben2=0; pending=0 after edge 2.
REQ-033 Three-way contention: producers 0,1,2 send tags 1,2,3 at edge 1 with rr_ptr=0 -> edge 2 broadcasts tags 1 and 2; edge 3 broadcasts tag 3 on port 1; conflict_count=1; rr_ptr=3.
REQ-034 Backpressure: producer 2 held and not granted -> req_ready[2]=0; producer 2 holds valid with tag 7 -> tag 7 is accepted only on its grant edge and broadcast one cycle later.
REQ-035 Flush mid-operation: four results held, flush pulsed one cycle -> both outputs show tag 0 the next cycle, pending=0, and none of the four tags ever appears.
REQ-036 Tag-0 drop and reset: producer 1 sends tag 0 -> nothing broadcast. rst asserted mid-cycle with results held -> outputs, pending and conflict_count go to 0 immediately.
REQ-037 Random soak of 10k cycles: every accepted non-zero tag is broadcast exactly once, in at most 2 cycles, unless flushed.
